// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry full adder with combinational and registered sum/carry-out
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] S,
    output logic             D,
    output logic [WIDTH-1:0] S_Q,
    output logic             D_Q
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0] carry;

    assign carry[0] = C;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end

    assign D = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            S_Q <= '0;
            D_Q <= 1'b0;
        end else begin
            S_Q <= S;
            D_Q <= D;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH=1 and WIDTH=4
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, c1;
    logic       s1, d1, sq1, dq1;
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] s4, sq4;
    logic       d4, dq4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1),
        .S(s1), .D(d1), .S_Q(sq1), .D_Q(dq1)
    );

    full_adder #(.WIDTH(4)) u_fa4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .C(c4),
        .S(s4), .D(d4), .S_Q(sq4), .D_Q(dq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference: plain 5-bit arithmetic sum
    function automatic logic [4:0] ref_sum4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(a) + 5'(b) + 5'(c);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] tt_exp [8];
        logic [1:0] held;
        logic [4:0] exp5;
        logic [4:0] prev5;
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // reset priority with all-ones inputs
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            check("rst_sq1", 32'(sq1), 32'd0);
            check("rst_dq1", 32'(dq1), 32'd0);
            check("rst_s1",  32'(s1),  32'd1);
            check("rst_d1",  32'(d1),  32'd1);
            check("rst_sq4", 32'(sq4), 32'd0);
            check("rst_dq4", 32'(dq4), 32'd0);
            check("rst_ones4", 32'({d4, s4}), 32'h1F);
        end

        // exhaustive truth table at WIDTH=1
        for (int v = 0; v < 8; v++) begin
            {a1, b1, c1} = 3'(v);
            #10;
            check($sformatf("tt_%0d", v), 32'({d1, s1}), 32'(tt_exp[v]));
            check($sformatf("tt_arith_%0d", v), 32'({d1, s1}),
                  32'(2'(a1) + 2'(b1) + 2'(c1)));
        end
        held = {d1, s1};
        #100;
        check("tt_hold", 32'({d1, s1}), 32'(2'b11));
        check("tt_stable", 32'({d1, s1}), 32'(held));

        // register latency: 000 captured, then 111 applied between edges
        @(negedge clk);
        rst = 1'b0;
        {a1, b1, c1} = 3'b000;
        @(negedge clk);
        check("lat_pre_sq", 32'(sq1), 32'd0);
        check("lat_pre_dq", 32'(dq1), 32'd0);
        {a1, b1, c1} = 3'b111;
        #1;
        check("lat_hold_sq", 32'(sq1), 32'd0);
        check("lat_hold_dq", 32'(dq1), 32'd0);
        @(posedge clk);
        #1;
        check("lat_post_sq", 32'(sq1), 32'd1);
        check("lat_post_dq", 32'(dq1), 32'd1);

        // reset mid-stream with 011 registered
        @(negedge clk);
        {a1, b1, c1} = 3'b011;
        @(negedge clk);
        check("mid_run_sq", 32'(sq1), 32'd0);
        check("mid_run_dq", 32'(dq1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sq", 32'(sq1), 32'd0);
        check("mid_rst_dq", 32'(dq1), 32'd0);
        check("mid_rst_comb", 32'({d1, s1}), 32'(2'b10));
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_sq", 32'(sq1), 32'd0);
        check("mid_rel_dq", 32'(dq1), 32'd1);

        // WIDTH=4 directed boundary cases
        a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
        #1;
        check("w4_f0c1", 32'({d4, s4}), 32'h10);
        a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
        #1;
        check("w4_78c0", 32'({d4, s4}), 32'h0F);

        // WIDTH=4 random, combinational and one-cycle registered
        @(negedge clk);
        prev5 = ref_sum4(a4, b4, c4);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            check($sformatf("w4_reg_%0d", n), 32'({dq4, sq4}), 32'(prev5));
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            c4 = 1'($urandom);
            #1;
            exp5 = ref_sum4(a4, b4, c4);
            check($sformatf("w4_comb_%0d", n), 32'({d4, s4}), 32'(exp5));
            prev5 = exp5;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
